// File: rtl/cpu6_mem_lsu_pkg.sv
// cpu6_mem_lsu_pkg: shared types and constants for the MEM-stage load/store unit.
//   CPU6_XLEN                 datapath width
//   CPU6_LSU_STATE_WIDTH      FSM state width, with state codes CPU6_LSU_IDLE/REQ/RESP/DONE
//   CPU6_LSU_TIMEOUT_DEFAULT  default outstanding-access limit, in cycles
package cpu6_mem_lsu_pkg;
    localparam int CPU6_XLEN                = 32;
    localparam int CPU6_LSU_STATE_WIDTH     = 2;
    localparam int CPU6_LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [CPU6_LSU_STATE_WIDTH-1:0] {
        CPU6_LSU_IDLE = 2'd0,
        CPU6_LSU_REQ  = 2'd1,
        CPU6_LSU_RESP = 2'd2,
        CPU6_LSU_DONE = 2'd3
    } lsuState_t;

    // Request registers: held stable on the bus until the fabric accepts them.
    typedef struct packed {
        logic [CPU6_XLEN-1:0] addr;
        logic                 wen;
        logic [CPU6_XLEN-1:0] wdata;
    } lsuReq_t;

    function automatic logic isMisaligned(input logic [CPU6_XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/cpu6_mem_lsu_if.sv
// cpu6_mem_lsu_if: data-bus valid/ready request channel plus always-accepted response.
//   master: the LSU (drives dbus_req_*, receives ready and response)
//   slave : the memory fabric
interface cpu6_mem_lsu_if import cpu6_mem_lsu_pkg::*; ();
    logic                 dbus_req_valid;
    logic                 dbus_req_ready;
    logic [CPU6_XLEN-1:0] dbus_req_addr;
    logic                 dbus_req_wen;
    logic [CPU6_XLEN-1:0] dbus_req_wdata;
    logic                 dbus_rsp_valid;
    logic [CPU6_XLEN-1:0] dbus_rsp_rdata;

    modport master (
        output dbus_req_valid, dbus_req_addr, dbus_req_wen, dbus_req_wdata,
        input  dbus_req_ready, dbus_rsp_valid, dbus_rsp_rdata
    );

    modport slave (
        input  dbus_req_valid, dbus_req_addr, dbus_req_wen, dbus_req_wdata,
        output dbus_req_ready, dbus_rsp_valid, dbus_rsp_rdata
    );
endinterface

// File: rtl/cpu6_lsu_timer.sv
// cpu6_lsu_timer: outstanding-access timer.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart count at zero (access entering REQ)
//   en         : count this cycle (access outstanding)
//   tc         : terminal count, high while counting and count == TIMEOUT_CYCLES-1
module cpu6_lsu_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // The access is always aborted at TC_VAL, so the count never wraps.
    always_ff @(posedge clk) begin
        if (reset)    count <= '0;
        else if (clr) count <= '0;
        else if (en)  count <= count + CW'(1);
    end

    assign tc = en && (count == TC_VAL);
endmodule

// File: rtl/cpu6_mem_lsu.sv
// cpu6_mem_lsu: MEM-stage load/store unit. Turns each M-stage load/store into one
// data-bus transaction, stalls the pipeline until it completes, and presents the
// result for one cycle.
//   clk, reset                 clock, synchronous active-high reset
//   memwriteM, memtoregM       store / load in M (both set = store)
//   aluout_typeuimmM           byte address;  writedataM  store data
//   dbus                       data bus (master side)
//   stallM                     hold PC, IF/ID, ID/EX, EX/MEM
//   readdataM                  load result (valid with lsu_doneM on a load)
//   lsu_doneM                  access completes this cycle
//   misalign_errM, bus_errM    error pulses coincident with lsu_doneM
module cpu6_mem_lsu import cpu6_mem_lsu_pkg::*; #(
    parameter int TIMEOUT_CYCLES = CPU6_LSU_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memwriteM,
    input  logic                 memtoregM,
    input  logic [CPU6_XLEN-1:0] aluout_typeuimmM,
    input  logic [CPU6_XLEN-1:0] writedataM,
    cpu6_mem_lsu_if.master       dbus,
    output logic                 stallM,
    output logic [CPU6_XLEN-1:0] readdataM,
    output logic                 lsu_doneM,
    output logic                 misalign_errM,
    output logic                 bus_errM
);
    lsuState_t state;
    lsuReq_t   req;
    logic      reqValid;
    logic      access;
    logic      misaligned;
    logic      timerClr;
    logic      timerEn;
    logic      timeout;

    assign access     = memwriteM | memtoregM;
    assign misaligned = isMisaligned(aluout_typeuimmM);
    assign timerClr   = (state == CPU6_LSU_IDLE) && access && !misaligned;
    assign timerEn    = (state == CPU6_LSU_REQ) || (state == CPU6_LSU_RESP);

    cpu6_lsu_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uTimer (
        .clk   (clk),
        .reset (reset),
        .clr   (timerClr),
        .en    (timerEn),
        .tc    (timeout)
    );

    // Error flags are rewritten every cycle, so they are high only in DONE.
    // In REQ the abort wins over a handshake on the terminal cycle; in RESP a
    // response on the terminal cycle wins over the abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CPU6_LSU_IDLE;
            req           <= '0;
            reqValid      <= 1'b0;
            readdataM     <= '0;
            misalign_errM <= 1'b0;
            bus_errM      <= 1'b0;
        end else begin
            misalign_errM <= 1'b0;
            bus_errM      <= 1'b0;
            case (state)
                CPU6_LSU_IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            state         <= CPU6_LSU_DONE;
                            misalign_errM <= 1'b1;
                        end else begin
                            state     <= CPU6_LSU_REQ;
                            reqValid  <= 1'b1;
                            req.addr  <= {aluout_typeuimmM[CPU6_XLEN-1:2], 2'b00};
                            req.wen   <= memwriteM;
                            req.wdata <= writedataM;
                        end
                    end
                end
                CPU6_LSU_REQ: begin
                    if (timeout) begin
                        state    <= CPU6_LSU_DONE;
                        reqValid <= 1'b0;
                        bus_errM <= 1'b1;
                        if (!req.wen) readdataM <= '0;
                    end else if (dbus.dbus_req_ready) begin
                        state    <= CPU6_LSU_RESP;
                        reqValid <= 1'b0;
                    end
                end
                CPU6_LSU_RESP: begin
                    if (dbus.dbus_rsp_valid) begin
                        state <= CPU6_LSU_DONE;
                        if (!req.wen) readdataM <= dbus.dbus_rsp_rdata;
                    end else if (timeout) begin
                        state    <= CPU6_LSU_DONE;
                        bus_errM <= 1'b1;
                        if (!req.wen) readdataM <= '0;
                    end
                end
                default: state <= CPU6_LSU_IDLE;
            endcase
        end
    end

    assign lsu_doneM           = (state == CPU6_LSU_DONE);
    assign stallM              = access && (state != CPU6_LSU_DONE);
    assign dbus.dbus_req_valid = reqValid;
    assign dbus.dbus_req_addr  = req.addr;
    assign dbus.dbus_req_wen   = req.wen;
    assign dbus.dbus_req_wdata = req.wdata;
endmodule

// File: tb/tb_cpu6_mem_lsu.sv
// tb_cpu6_mem_lsu: directed bench. Each access is described by its fabric
// behaviour (ready delay, response delay); the expected timeline (request
// window, completion cycle, error kind, load result) is computed in closed form
// and checked every cycle by one compare process.
module tb_cpu6_mem_lsu;
    import cpu6_mem_lsu_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwriteM = 1'b0;
    logic        memtoregM = 1'b0;
    logic [31:0] aluout_typeuimmM = '0;
    logic [31:0] writedataM = '0;
    logic        stallM, lsu_doneM, misalign_errM, bus_errM;
    logic [31:0] readdataM;

    cpu6_mem_lsu_if dbusIf ();

    cpu6_mem_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk              (clk),
        .reset            (reset),
        .memwriteM        (memwriteM),
        .memtoregM        (memtoregM),
        .aluout_typeuimmM (aluout_typeuimmM),
        .writedataM       (writedataM),
        .dbus             (dbusIf),
        .stallM           (stallM),
        .readdataM        (readdataM),
        .lsu_doneM        (lsu_doneM),
        .misalign_errM    (misalign_errM),
        .bus_errM         (bus_errM)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // expected timeline of the current access
    bit          chkOn = 1'b0;
    int          eReqFirst = -1, eReqLast = -1, eDone = -1, rdSwitch = 0;
    bit          eMis = 1'b0, eBus = 1'b0, eWen = 1'b0;
    logic [31:0] eAddr = '0, eWd = '0, rdOld = '0, rdNew = '0, mRd = '0;
    int          stallCnt = 0;
    bit          inReq, isDone;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chkOn) begin
            inReq  = (eReqFirst >= 0) && (cyc >= eReqFirst) && (cyc <= eReqLast);
            isDone = (cyc == eDone);
            check1("stallM", stallM, (memwriteM | memtoregM) && !isDone);
            check1("lsu_doneM", lsu_doneM, isDone);
            check1("misalign_errM", misalign_errM, isDone && eMis);
            check1("bus_errM", bus_errM, isDone && eBus);
            check1("req_valid", dbusIf.dbus_req_valid, inReq);
            if (inReq) begin
                check32("req_addr", dbusIf.dbus_req_addr, eAddr);
                check1("req_wen", dbusIf.dbus_req_wen, eWen);
                check32("req_wdata", dbusIf.dbus_req_wdata, eWd);
            end
            check32("readdataM", readdataM, (cyc >= rdSwitch) ? rdNew : rdOld);
            if (stallM) stallCnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        memwriteM = 1'b0;
        memtoregM = 1'b0;
        step(n);
    endtask

    // One access. R = cycles ready stays low in REQ, D = response delay after
    // acceptance (0 = never). Returns start and completion cycles; leaves the
    // access inputs asserted in the cycle after completion.
    task automatic txn(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] wd,
                       input int R, input int D, input logic [31:0] rd,
                       output int s, output int dn);
        int  h;
        bit  mis, berr;
        logic [31:0] nv;
        s   = cyc;
        mis = (a[1:0] != 2'b00);
        h   = -1;
        berr = 1'b0;
        if (mis) begin
            eReqFirst = -1; eReqLast = -1; dn = s + 1;
        end else begin
            eReqFirst = s + 1;
            h = s + 1 + R;
            if (h >= s + T) begin
                eReqLast = s + T; dn = s + T + 1; berr = 1'b1;
            end else begin
                eReqLast = h;
                if (D > 0 && h + D <= s + T) dn = h + D + 1;
                else begin dn = s + T + 1; berr = 1'b1; end
            end
        end
        nv = mRd;
        if (ld && !st && !mis) nv = berr ? 32'h0 : rd;
        eDone = dn; eMis = mis; eBus = berr; eWen = st;
        eAddr = {a[31:2], 2'b00}; eWd = wd;
        rdOld = mRd; rdNew = nv; rdSwitch = dn;
        memwriteM = st; memtoregM = ld; aluout_typeuimmM = a; writedataM = wd;
        dbusIf.dbus_rsp_rdata = rd;
        while (cyc < dn + 1) begin
            dbusIf.dbus_req_ready = (h >= 0) && (cyc >= h);
            dbusIf.dbus_rsp_valid = (D > 0) && (h >= 0) && (cyc == h + D);
            step(1);
        end
        dbusIf.dbus_req_ready = 1'b0;
        dbusIf.dbus_rsp_valid = 1'b0;
        mRd = nv;
    endtask

    int s, d, d1, r;

    initial begin
        dbusIf.dbus_req_ready = 1'b0;
        dbusIf.dbus_rsp_valid = 1'b0;
        dbusIf.dbus_rsp_rdata = '0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chkOn = 1'b1;
        check1("reset_valid", dbusIf.dbus_req_valid, 1'b0);
        check1("reset_done", lsu_doneM, 1'b0);
        check32("reset_readdata", readdataM, 32'h0);
        idle(1);

        // best-case load
        stallCnt = 0;
        txn(0, 1, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, s, d);
        check32("best_latency", 32'(d - s), 32'd3);
        check32("best_stalls", 32'(stallCnt), 32'd3);
        check32("best_data", readdataM, 32'hDEADBEEF);
        idle(2);

        // store with ready low for 4 cycles
        txn(1, 0, 32'h204, 32'h12345678, 4, 1, 32'hFFFF0000, s, d);
        check32("store_latency", 32'(d - s), 32'd7);
        check32("store_keeps_data", readdataM, 32'hDEADBEEF);
        idle(2);

        // misaligned load
        stallCnt = 0;
        txn(0, 1, 32'h103, 32'h0, 0, 1, 32'h0, s, d);
        check32("mis_latency", 32'(d - s), 32'd1);
        check32("mis_stalls", 32'(stallCnt), 32'd1);
        idle(1);
        txn(1, 0, 32'h206, 32'hAAAA, 0, 1, 32'h0, s, d);
        idle(1);

        // response on the terminal cycle still completes
        txn(0, 1, 32'h300, 32'h0, 0, T - 1, 32'h600DF00D, s, d);
        check32("edge_rsp_latency", 32'(d - s), 32'(T + 1));
        check32("edge_rsp_data", readdataM, 32'h600DF00D);
        idle(1);

        // response one cycle too late: timeout, late response ignored
        txn(0, 1, 32'h304, 32'h0, 0, T, 32'h0BADBAD0, s, d);
        check32("late_rsp_data", readdataM, 32'h0);
        idle(1);

        // no response at all
        txn(1, 1, 32'h208, 32'hCAFE, 0, 1, 32'h5555, s, d);   // both set: store
        idle(1);
        txn(0, 1, 32'h10, 32'h0, 0, 3, 32'hA5A5A5A5, s, d);
        idle(1);
        txn(0, 1, 32'h180, 32'h0, 0, 0, 32'h0, s, d);
        check32("timeout_latency", 32'(d - s), 32'(T + 1));
        check32("timeout_data", readdataM, 32'h0);
        memwriteM = 1'b0; memtoregM = 1'b0;
        dbusIf.dbus_rsp_valid = 1'b1;                        // stray response
        dbusIf.dbus_rsp_rdata = 32'h13579BDF;
        step(1);
        dbusIf.dbus_rsp_valid = 1'b0;
        check32("stray_ignored", readdataM, 32'h0);
        idle(1);

        // request never accepted: abort from REQ
        txn(1, 0, 32'h400, 32'h99, 20, 1, 32'h0, s, d);
        check32("req_timeout_latency", 32'(d - s), 32'(T + 1));
        idle(1);

        // reset while in RESP
        txn(0, 1, 32'h20, 32'h0, 0, 1, 32'h0F0F0F0F, s, d);
        idle(1);
        s = cyc;
        eReqFirst = s + 1; eReqLast = s + 1; eDone = -1; eMis = 0; eBus = 0;
        eWen = 0; eAddr = 32'h40; eWd = 32'h0;
        rdOld = mRd; rdNew = mRd; rdSwitch = 0;
        memtoregM = 1'b1; aluout_typeuimmM = 32'h40; writedataM = 32'h0;
        dbusIf.dbus_req_ready = 1'b1;
        step(3);
        r = cyc;
        reset = 1'b1;
        memtoregM = 1'b0;
        rdNew = 32'h0; rdSwitch = r + 1;
        step(1);
        reset = 1'b0;
        mRd = 32'h0;
        dbusIf.dbus_req_ready = 1'b0;
        check1("rst_mid_valid", dbusIf.dbus_req_valid, 1'b0);
        check1("rst_mid_stall", stallM, 1'b0);
        check1("rst_mid_done", lsu_doneM, 1'b0);
        check1("rst_mid_buserr", bus_errM, 1'b0);
        check32("rst_mid_readdata", readdataM, 32'h0);
        dbusIf.dbus_rsp_valid = 1'b1;                        // orphaned response
        dbusIf.dbus_rsp_rdata = 32'hEEEEEEEE;
        step(1);
        dbusIf.dbus_rsp_valid = 1'b0;
        txn(0, 1, 32'h44, 32'h0, 0, 1, 32'h77777777, s, d);
        check32("post_reset_data", readdataM, 32'h77777777);
        idle(2);

        // back-to-back loads
        txn(0, 1, 32'h0, 32'h0, 0, 1, 32'h11111111, s, d1);
        check32("b2b_first", readdataM, 32'h11111111);
        txn(0, 1, 32'h4, 32'h0, 0, 1, 32'h22222222, s, d);
        check32("b2b_spacing", 32'(d - d1), 32'd4);
        check32("b2b_second", readdataM, 32'h22222222);
        idle(3);

        chkOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu6_mem_lsu.md
# cpu6_mem_lsu

MEM-stage load/store unit: consumes the access fields that leave the EX/MEM pipeline register and turns each load or store into one transaction on the data bus using valid/ready handshakes. It holds the pipeline with `stallM` until the response returns. It then presents load data and the error flags to the MEM/WB register for exactly one cycle. The unit sits between the EX/MEM register outputs, the data-memory/bus fabric and the hazard unit.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles an access may stay outstanding (REQ+RESP) before it is aborted; legal range 2..65535.
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `memwriteM`  in  1  store in M stage
- `memtoregM`  in  1  load in M stage
- `aluout_typeuimmM`  in  `CPU6_XLEN`  byte address
- `writedataM`  in  `CPU6_XLEN`  store data
- `dbus_req_valid`  out  1  request valid
- `dbus_req_ready`  in  1  fabric accepts request
- `dbus_req_addr`  out  `CPU6_XLEN`  word-aligned address
- `dbus_req_wen`  out  1  1 = store, 0 = load
- `dbus_req_wdata`  out  `CPU6_XLEN`  store data
- `dbus_rsp_valid`  in  1  response/ack, always accepted
- `dbus_rsp_rdata`  in  `CPU6_XLEN`  load data
- `stallM`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- `readdataM`  out  `CPU6_XLEN`  load result, valid when `lsu_doneM` and load
- `lsu_doneM`  out  1  access completes this cycle
- `misalign_errM`  out  1  pulse with `lsu_doneM`: `aluout_typeuimmM[1:0]`≠0
- `bus_errM`  out  1  pulse with `lsu_doneM`: timeout

## Operation
- `access = memwriteM | memtoregM`; both set is illegal and is treated as a store.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: `access` with aligned address → capture addr, wen, wdata into request registers, go REQ. `access` with misaligned address → go DONE, set misalign flag, no bus request. Otherwise stay.
- REQ: `dbus_req_valid`=1; address, wen and wdata are stable until accepted. `valid & ready` → RESP. Timeout → DONE with bus error.
- RESP: `dbus_rsp_valid` → capture `dbus_rsp_rdata` into `readdataM` (loads only), go DONE. Timeout → DONE, bus error, `readdataM`←0 for loads.
- DONE: `lsu_doneM`=1, `stallM`=0, error flag output for this cycle only. Next state IDLE unconditionally. The pipeline advances at this edge.
- `stallM = access & (state != DONE)`; combinational from registered state and M-stage inputs.
- Timeout counter: clears on entry to REQ and increments each REQ/RESP cycle. The abort fires when the count equals `TIMEOUT_CYCLES-1`. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `readdataM` holds its value except on a load response, a load timeout, or reset. Stores never change it.
- `dbus_rsp_valid` outside RESP is ignored, which covers late responses after a timeout or reset.
- Request acceptance and response in the same cycle is not supported: the response counts only from the cycle after acceptance.

## Timing
- Reset values: state IDLE; `dbus_req_valid`, `stallM` (given state IDLE and no `access`), `lsu_doneM`, `misalign_errM`, `bus_errM` = 0; `readdataM`, request registers, counter = 0.
- Reset mid-transaction: the next cycle is IDLE with valid low. The outstanding fabric response is discarded. If `access` is still high after reset, a fresh request is issued.
- Best case, aligned access, `ready` high, response one cycle later: access visible at cycle 0 (IDLE), req handshake at cycle 1, rsp at cycle 2, DONE at cycle 3. `stallM` is high in cycles 0–2, so there are 3 stall cycles.
- Misaligned access: IDLE at cycle 0 with stall, DONE at cycle 1. One stall cycle.
- Back-to-back accesses: DONE→IDLE costs one cycle before the next request, so the minimum spacing is 4 cycles per access.
- `dbus_req_*` are driven from registers only, with no combinational path from any input.

## Structure
- Add to `defines.v`: `CPU6_LSU_STATE_WIDTH` (2), the state codes `CPU6_LSU_IDLE/REQ/RESP/DONE`, and `CPU6_LSU_TIMEOUT_DEFAULT` (255).
- All flops are `cpu6_dffr` instances, or an enable variant for the request and readdata registers.
- Sub-module `cpu6_lsu_timer`: clear/enable counter with a terminal-count output, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Load from 0x100, `ready`=1, rsp 1 cycle later with 0xDEADBEEF → `stallM` high 3 cycles; `readdataM`=0xDEADBEEF with `lsu_doneM` at cycle 3.
- Store of 0x12345678 to 0x204 with `ready` low for 4 cycles → `dbus_req_*` held stable while waiting; `dbus_req_wen`=1; `readdataM` unchanged after completion.
- Load from 0x103 → no `dbus_req_valid`; `misalign_errM`=`lsu_doneM`=1 at cycle 1.
- `TIMEOUT_CYCLES`=8, `ready`=1, no response → `bus_errM` pulse after 8 outstanding cycles; `readdataM`=0; a later stray `dbus_rsp_valid` is ignored.
- Reset asserted while in RESP → IDLE next cycle with all outputs at reset values; the following load completes normally.
- Two loads back-to-back (0x0 then 0x4) → two handshakes, DONE pulses 4 cycles apart, correct data for each.
